// File: rtl/tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tx_os_scheduler
// Description : Gen1/Gen2 (8b/10b) single-lane transmit symbol scheduler.
//               Shares the lane between framed packet symbols, periodic SKP
//               ordered sets, EIOS on request and logical-idle (D0.0) fill,
//               and drives the transmitter electrical-idle control.
// Ports       : clk, rst_n             - symbol clock, async active-low reset
//               pkt_valid/data/k/last  - framed link-layer symbol source
//               pkt_ready              - symbol accepted this cycle (comb.)
//               eidle_req              - level request for EIOS + elec. idle
//               tx_data/tx_k           - registered symbol to the encoder
//               tx_elec_idle           - registered transmitter idle control
//               skp_sent/eios_done/underrun_err - registered event pulses
// Revision    : 1.0 - initial release
// ============================================================================
module tx_os_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pkt_valid,
    input  logic [7:0] pkt_data,
    input  logic       pkt_k,
    input  logic       pkt_last,
    output logic       pkt_ready,
    input  logic       eidle_req,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic       tx_elec_idle,
    output logic       skp_sent,
    output logic       eios_done,
    output logic       underrun_err
);

    localparam logic [7:0] c_sym_com  = 8'hBC;
    localparam logic [7:0] c_sym_skp  = 8'h1C;
    localparam logic [7:0] c_sym_idl  = 8'h7C;
    localparam logic [7:0] c_sym_edb  = 8'hFE;
    localparam logic [7:0] c_sym_fill = 8'h00;

    // ST_FILL is the packet boundary: the COM of a SKP or EIOS is emitted
    // straight from it, so ST_SKP / ST_EIOS only cover ordered-set idx 1..3.
    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_PKT   = 3'd1,
        ST_SKP   = 3'd2,
        ST_EIOS  = 3'd3,
        ST_EIDLE = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skp_pend_q, skp_pend_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_k_q, tx_k_d;
    logic             tx_elec_idle_q, tx_elec_idle_d;
    logic             skp_sent_q, skp_sent_d;
    logic             eios_done_q, eios_done_d;
    logic             underrun_err_q, underrun_err_d;

    logic             count_en;
    logic             skp_start;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the compare cannot wrap when CNT_W is tight.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        skp_pend_d     = skp_pend_q;
        tx_data_d      = c_sym_fill;
        tx_k_d         = 1'b0;
        tx_elec_idle_d = 1'b0;
        skp_sent_d     = 1'b0;
        eios_done_d    = 1'b0;
        underrun_err_d = 1'b0;
        pkt_ready      = 1'b0;
        count_en       = 1'b1;
        skp_start      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (skp_pend_q) begin
                    tx_data_d  = c_sym_com;
                    tx_k_d     = 1'b1;
                    skp_sent_d = 1'b1;
                    skp_start  = 1'b1;
                    count_en   = 1'b0;
                    state_d    = ST_SKP;
                    idx_d      = 2'd1;
                end else if (eidle_req) begin
                    tx_data_d = c_sym_com;
                    tx_k_d    = 1'b1;
                    state_d   = ST_EIOS;
                    idx_d     = 2'd1;
                end else begin
                    pkt_ready = 1'b1;
                    if (pkt_valid) begin
                        tx_data_d = pkt_data;
                        tx_k_d    = pkt_k;
                        if (!pkt_last) begin
                            state_d = ST_PKT;
                        end
                    end
                end
            end
            ST_PKT: begin
                pkt_ready = 1'b1;
                if (!pkt_valid) begin
                    // Source starved mid-packet: nullify with EDB and discard
                    // the remainder of the packet; pkt_last is ignored here.
                    tx_data_d      = c_sym_edb;
                    tx_k_d         = 1'b1;
                    underrun_err_d = 1'b1;
                    state_d        = ST_DRAIN;
                end else begin
                    tx_data_d = pkt_data;
                    tx_k_d    = pkt_k;
                    if (pkt_last) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_SKP: begin
                tx_data_d = c_sym_skp;
                tx_k_d    = 1'b1;
                count_en  = 1'b0;
                if (idx_q == 2'd3) begin
                    state_d = ST_FILL;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_EIOS: begin
                tx_data_d = c_sym_idl;
                tx_k_d    = 1'b1;
                if (idx_q == 2'd3) begin
                    eios_done_d = 1'b1;
                    state_d     = ST_EIDLE;
                    idx_d       = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_EIDLE: begin
                tx_elec_idle_d = 1'b1;
                count_en       = 1'b0;
                cnt_d          = '0;
                skp_pend_d     = 1'b0;
                if (!eidle_req) begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                pkt_ready = 1'b1;
                if (pkt_valid && pkt_last) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = 2'd0;
            end
        endcase

        // Only one SKP is ever owed: a second expiry while pending is absorbed.
        if (skp_start) begin
            cnt_d      = '0;
            skp_pend_d = 1'b0;
        end else if (count_en) begin
            if (cnt_inc >= (CNT_W+1)'(SKP_INTERVAL)) begin
                cnt_d      = '0;
                skp_pend_d = 1'b1;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_FILL;
            idx_q          <= 2'd0;
            cnt_q          <= '0;
            skp_pend_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            tx_k_q         <= 1'b0;
            tx_elec_idle_q <= 1'b0;
            skp_sent_q     <= 1'b0;
            eios_done_q    <= 1'b0;
            underrun_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            skp_pend_q     <= skp_pend_d;
            tx_data_q      <= tx_data_d;
            tx_k_q         <= tx_k_d;
            tx_elec_idle_q <= tx_elec_idle_d;
            skp_sent_q     <= skp_sent_d;
            eios_done_q    <= eios_done_d;
            underrun_err_q <= underrun_err_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_k         = tx_k_q;
    assign tx_elec_idle = tx_elec_idle_q;
    assign skp_sent     = skp_sent_q;
    assign eios_done    = eios_done_q;
    assign underrun_err = underrun_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_os_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_os_scheduler
// Description : Self-checking bench for tx_os_scheduler. A queue-based
//               behavioural model predicts pkt_ready and the registered
//               output symbol for every clock under directed and random
//               packet / eidle_req stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_os_scheduler;

    localparam int SKP_INTERVAL = 16;
    localparam int CNT_W        = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_k;
    logic       pkt_last;
    logic       pkt_ready;
    logic       eidle_req;
    logic [7:0] tx_data;
    logic       tx_k;
    logic       tx_elec_idle;
    logic       skp_sent;
    logic       eios_done;
    logic       underrun_err;

    always #5 clk = ~clk;

    tx_os_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_valid    (pkt_valid),
        .pkt_data     (pkt_data),
        .pkt_k        (pkt_k),
        .pkt_last     (pkt_last),
        .pkt_ready    (pkt_ready),
        .eidle_req    (eidle_req),
        .tx_data      (tx_data),
        .tx_k         (tx_k),
        .tx_elec_idle (tx_elec_idle),
        .skp_sent     (skp_sent),
        .eios_done    (eios_done),
        .underrun_err (underrun_err)
    );

    typedef struct packed {
        logic       last;
        logic       k;
        logic [7:0] data;
    } src_sym_t;

    // Output vector layout: {elec, k, data[7:0], skp_sent, eios_done, underrun}
    src_sym_t    src_q[$];
    logic [12:0] os_q[$];
    bit          os_skp_q[$];

    int          checks = 0;
    int          errors = 0;

    bit          m_in_pkt, m_drain, m_idle, m_owed;
    int          m_since;
    logic        m_ready;
    logic [12:0] exp_out, exp_next;

    logic        eidle_drv;
    int          gap_pct;
    bit          force_gap;
    int          acc_cnt;

    function automatic logic [12:0] mk(input logic elec, input logic k, input logic [7:0] d,
                                       input logic skp, input logic eios, input logic und);
        return {elec, k, d, skp, eios, und};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        os_q.delete();
        os_skp_q.delete();
        m_in_pkt = 0;
        m_drain  = 0;
        m_idle   = 0;
        m_owed   = 0;
        m_since  = 0;
        exp_out  = 13'd0;
    endtask

    task automatic push_os(input logic [7:0] d, input bit is_skp, input bit last_eios);
        os_q.push_back(mk(1'b0, 1'b1, d, 1'b0, last_eios, 1'b0));
        os_skp_q.push_back(is_skp);
    endtask

    // Applies the scheduling rules to the current inputs: sets m_ready and
    // the symbol that will appear at the outputs after the next clock edge.
    task automatic model_step();
        logic [12:0] o;
        bit          counted;
        o       = 13'd0;
        counted = 1'b1;
        m_ready = 1'b0;
        if (os_q.size() != 0) begin
            o = os_q.pop_front();
            if (os_skp_q.pop_front()) counted = 1'b0;
            if (o[1]) m_idle = 1'b1;
        end else if (m_idle) begin
            o       = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            counted = 1'b0;
            m_since = 0;
            m_owed  = 0;
            if (!eidle_req) m_idle = 0;
        end else if (m_in_pkt) begin
            m_ready = 1'b1;
            if (!pkt_valid) begin
                o        = mk(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
                m_in_pkt = 0;
                m_drain  = 1;
            end else begin
                o = mk(1'b0, pkt_k, pkt_data, 1'b0, 1'b0, 1'b0);
                if (pkt_last) m_in_pkt = 0;
            end
        end else if (m_drain) begin
            m_ready = 1'b1;
            if (pkt_valid && pkt_last) m_drain = 0;
        end else if (m_owed) begin
            o = mk(1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) push_os(8'h1C, 1'b1, 1'b0);
            m_owed  = 0;
            m_since = 0;
            counted = 1'b0;
        end else if (eidle_req) begin
            o = mk(1'b0, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0);
            push_os(8'h7C, 1'b0, 1'b0);
            push_os(8'h7C, 1'b0, 1'b0);
            push_os(8'h7C, 1'b0, 1'b1);
        end else begin
            m_ready = 1'b1;
            if (pkt_valid) begin
                o = mk(1'b0, pkt_k, pkt_data, 1'b0, 1'b0, 1'b0);
                if (!pkt_last) m_in_pkt = 1;
            end
        end
        if (counted) begin
            m_since++;
            if (m_since >= SKP_INTERVAL) begin
                m_since = 0;
                m_owed  = 1;
            end
        end
        exp_next = o;
    endtask

    task automatic drive_src();
        bit gap;
        gap       = force_gap || ($urandom_range(99) < gap_pct);
        force_gap = 1'b0;
        eidle_req = eidle_drv;
        if (src_q.size() != 0 && !gap) begin
            pkt_valid = 1'b1;
            pkt_data  = src_q[0].data;
            pkt_k     = src_q[0].k;
            pkt_last  = src_q[0].last;
        end else begin
            pkt_valid = 1'b0;
            pkt_data  = 8'($urandom);
            pkt_k     = 1'($urandom);
            pkt_last  = 1'($urandom);
        end
    endtask

    task automatic push_pkt(input int len);
        src_sym_t s;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1)  s = '{last: 1'b1, k: 1'b1, data: 8'hFD};
            else if (i == 0)   s = '{last: 1'b0, k: 1'b1, data: 8'hFB};
            else               s = '{last: 1'b0, k: 1'b0, data: 8'($urandom)};
            src_q.push_back(s);
        end
    endtask

    // Called just after a falling edge; returns at the next falling edge
    // after comparing the registered outputs with the model.
    task automatic cycle();
        drive_src();
        #1;
        model_step();
        chk("pkt_ready", {31'd0, pkt_ready}, {31'd0, m_ready});
        if (m_ready && pkt_valid) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        exp_out = exp_next;
        @(negedge clk);
        chk("tx_out", {19'd0, tx_elec_idle, tx_k, tx_data, skp_sent, eios_done, underrun_err},
            {19'd0, exp_out});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic bit at_boundary();
        return !m_in_pkt && !m_drain && !m_idle && (os_q.size() == 0);
    endfunction

    initial begin
        int n;
        int acc0;
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = 8'h00;
        pkt_k     = 1'b0;
        pkt_last  = 1'b0;
        eidle_req = 1'b0;
        eidle_drv = 1'b0;
        gap_pct   = 0;
        force_gap = 1'b0;
        acc_cnt   = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", {19'd0, tx_elec_idle, tx_k, tx_data, skp_sent, eios_done, underrun_err}, 32'd0);
        rst_n = 1'b1;

        // Idle link: 16 fill symbols then SKP, period 20
        run(45);

        // 10-symbol packet started at fill symbol 12: SKP deferred past FD
        n = 0;
        while (!(at_boundary() && !m_owed && m_since == 12) && n < 200) begin cycle(); n++; end
        chk("wait_fill12", {31'd0, n < 200}, 32'd1);
        acc0 = acc_cnt;
        push_pkt(10);
        run(30);
        chk("pkt10_consumed", acc_cnt - acc0, 32'd10);

        // eidle_req raised mid-packet
        push_pkt(8);
        run(3);
        eidle_drv = 1'b1;
        run(20);
        eidle_drv = 1'b0;
        run(25);

        // Underrun after 3 accepted symbols
        acc0 = acc_cnt;
        push_pkt(8);
        n = 0;
        while (acc_cnt - acc0 < 3 && n < 200) begin cycle(); n++; end
        chk("wait_3sym", {31'd0, n < 200}, 32'd1);
        force_gap = 1'b1;
        run(20);
        chk("drain_consumed", src_q.size(), 32'd0);

        // skp_pend and eidle_req at the same boundary
        n = 0;
        while (!(at_boundary() && m_owed) && n < 200) begin cycle(); n++; end
        chk("wait_pend", {31'd0, n < 200}, 32'd1);
        eidle_drv = 1'b1;
        run(15);
        eidle_drv = 1'b0;
        run(10);

        // Asynchronous reset while SKP idx 2 is on the outputs
        n = 0;
        while (!(exp_out == mk(1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0) && os_q.size() == 1) && n < 200) begin
            cycle();
            n++;
        end
        chk("wait_skp2", {31'd0, n < 200}, 32'd1);
        pkt_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("async_rst", {19'd0, tx_elec_idle, tx_k, tx_data, skp_sent, eios_done, underrun_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        src_q.delete();
        run(25);

        // Randomized traffic with gaps, underruns and eidle episodes
        gap_pct = 3;
        for (int c = 0; c < 3000; c++) begin
            if (src_q.size() == 0 && $urandom_range(99) < 20) push_pkt($urandom_range(1, 12));
            if (eidle_drv) begin
                if ($urandom_range(99) < 5) eidle_drv = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                eidle_drv = 1'b1;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
